adc_capture_gate: RTL and testbench



---
 rtl/adc_capture_gate_pkg.sv | 29 ++
 rtl/adc_capture_gate.sv | 193 +++++++++++++++++++
 tb/tb_adc_capture_gate.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/adc_capture_gate_pkg.sv
// -----------------------------------------------------------------------------
// adc_capture_gate_pkg
//   Shared types and helpers for the ADC capture gate.
//
//   Contents:
//     gate_state_t : FSM state encoding (IDLE, DELAY, GATE, POST, FRST)
//     max4()       : largest of four integers, used to size the down-counter
// -----------------------------------------------------------------------------
package adc_capture_gate_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DELAY = 3'd1,
      GATE  = 3'd2,
      POST  = 3'd3,
      FRST  = 3'd4
   } gate_state_t;

   // Largest of four values. The counter must hold (largest parameter - 1).
   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/adc_capture_gate.sv
// -----------------------------------------------------------------------------
// adc_capture_gate
//   Turns one rising edge on capture_i into a timed sequence:
//     DELAY : GATE_DELAY cycles of zeros to the filter
//     GATE  : GATE_LEN cycles of ADC data passed through (1-cycle latency)
//     POST  : POST_DELAY cycles of zeros
//     FRST  : RESET_LEN cycles with filt_rst_o high
//   then back to IDLE with a one-cycle done_o pulse.
//   The stream is assumed continuous: adc_tvalid and gate_tready are ignored,
//   adc_tready is tied high and gate_tvalid is high from the first edge after
//   reset release.
//
//   Ports:
//     aclk        in   stream clock
//     aresetn     in   asynchronous active-low reset
//     capture_i   in   capture request, rising edge triggers
//     adc_tdata   in   [DWIDTH] ADC stream data
//     adc_tvalid  in   ADC valid (ignored)
//     adc_tready  out  constant 1
//     gate_tdata  out  [DWIDTH] gated data (ADC data in GATE, zero otherwise)
//     gate_tvalid out  gated stream valid
//     gate_tready in   ignored, no backpressure
//     filt_rst_o  out  downstream filter reset, high during FRST
//     busy_o      out  sequence in progress
//     done_o      out  one-cycle pulse on the first IDLE cycle after FRST
//
//   Handshake: both streams are free-running. A beat is transferred on every
//   aclk edge regardless of tvalid/tready; tvalid is reported for downstream
//   compatibility only.
//
//   Optional build macro: ADC_CAPTURE_GATE_RETRIGGER_EN
//     defined   : a capture edge in any non-IDLE state restarts at DELAY and the
//                 aborted sequence produces no done_o pulse
//     undefined : capture edges outside IDLE are ignored
// -----------------------------------------------------------------------------
module adc_capture_gate
   import adc_capture_gate_pkg::*;
#(
   parameter int DWIDTH     = 128,
   parameter int GATE_DELAY = 32,
   parameter int GATE_LEN   = 64,
   parameter int POST_DELAY = 64,
   parameter int RESET_LEN  = 32
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              capture_i,
   input  logic [DWIDTH-1:0] adc_tdata,
   input  logic              adc_tvalid,
   output logic              adc_tready,
   output logic [DWIDTH-1:0] gate_tdata,
   output logic              gate_tvalid,
   input  logic              gate_tready,
   output logic              filt_rst_o,
   output logic              busy_o,
   output logic              done_o
);

   // ---------------------------------------------------------------------------
   // Parameter sanity: every phase must last at least one cycle, otherwise the
   // load value (N-1) would underflow the counter.
   // ---------------------------------------------------------------------------
   if (GATE_DELAY < 1) begin : g_bad_gate_delay
      $error("adc_capture_gate: GATE_DELAY must be >= 1");
   end
   if (GATE_LEN < 1) begin : g_bad_gate_len
      $error("adc_capture_gate: GATE_LEN must be >= 1");
   end
   if (POST_DELAY < 1) begin : g_bad_post_delay
      $error("adc_capture_gate: POST_DELAY must be >= 1");
   end
   if (RESET_LEN < 1) begin : g_bad_reset_len
      $error("adc_capture_gate: RESET_LEN must be >= 1");
   end

   localparam int CNT_W = $clog2(max4(GATE_DELAY, GATE_LEN, POST_DELAY, RESET_LEN)) + 1;

   // Each state is entered with (length - 1) so it lasts exactly "length" cycles.
   localparam logic [CNT_W-1:0] DELAY_LD = CNT_W'(GATE_DELAY - 1);
   localparam logic [CNT_W-1:0] GATE_LD  = CNT_W'(GATE_LEN - 1);
   localparam logic [CNT_W-1:0] POST_LD  = CNT_W'(POST_DELAY - 1);
   localparam logic [CNT_W-1:0] FRST_LD  = CNT_W'(RESET_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   gate_state_t      state;
   gate_state_t      next_state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] next_cnt;
   logic             cap_q;
   logic             trig;
   logic             cnt_zero;

   // Stream is continuous; these inputs carry no information for this block.
   logic unused_stream_ctrl;
   assign unused_stream_ctrl = adc_tvalid ^ gate_tready;

   assign adc_tready = 1'b1;

   // A held level triggers once: only the 0->1 transition counts.
   assign trig     = capture_i & ~cap_q;
   assign cnt_zero = (cnt == '0);

   // ---------------------------------------------------------------------------
   // Next-state / counter logic
   // ---------------------------------------------------------------------------
   always_comb begin
      next_state = state;
      next_cnt   = cnt;

      case (state)
         IDLE: begin
            if (trig) begin
               next_state = DELAY;
               next_cnt   = DELAY_LD;
            end
         end
         DELAY: begin
            if (cnt_zero) begin
               next_state = GATE;
               next_cnt   = GATE_LD;
            end else begin
               next_cnt = cnt - CNT_ONE;
            end
         end
         GATE: begin
            if (cnt_zero) begin
               next_state = POST;
               next_cnt   = POST_LD;
            end else begin
               next_cnt = cnt - CNT_ONE;
            end
         end
         POST: begin
            if (cnt_zero) begin
               next_state = FRST;
               next_cnt   = FRST_LD;
            end else begin
               next_cnt = cnt - CNT_ONE;
            end
         end
         FRST: begin
            if (cnt_zero) begin
               next_state = IDLE;
               next_cnt   = '0;
            end else begin
               next_cnt = cnt - CNT_ONE;
            end
         end
         default: begin
            next_state = IDLE;
            next_cnt   = '0;
         end
      endcase

`ifdef ADC_CAPTURE_GATE_RETRIGGER_EN
      // A new edge mid-sequence overrides whatever the case above decided,
      // including the FRST->IDLE exit, so the aborted run never reports done.
      if (trig && (state != IDLE)) begin
         next_state = DELAY;
         next_cnt   = DELAY_LD;
      end
`endif
   end

   // ---------------------------------------------------------------------------
   // State, edge register and registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state       <= IDLE;
         cnt         <= '0;
         cap_q       <= 1'b0;
         gate_tdata  <= '0;
         gate_tvalid <= 1'b0;
         filt_rst_o  <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
      end else begin
         state       <= next_state;
         cnt         <= next_cnt;
         cap_q       <= capture_i;
         gate_tvalid <= 1'b1;
         // Current (not next) state gates the data: the beat sampled on the
         // edge that leaves GATE is still the last window beat.
         gate_tdata  <= (state == GATE) ? adc_tdata : '0;
         // Status flags use next_state so they line up with the state itself.
         filt_rst_o  <= (next_state == FRST);
         busy_o      <= (next_state != IDLE);
         done_o      <= (state == FRST) && (next_state == IDLE);
      end
   end

endmodule

// File: tb/tb_adc_capture_gate.sv
// -----------------------------------------------------------------------------
// tb_adc_capture_gate
//   Directed bench for adc_capture_gate with GATE_DELAY=4, GATE_LEN=8,
//   POST_DELAY=3, RESET_LEN=2. adc_tdata carries an edge number so each window
//   beat is identifiable. Relative edge j=0 is the capture edge; after edge j:
//     gate data valid for j=5..12, busy for j=0..16, filt_rst at j=15,16,
//     done at j=17.
//   With ADC_CAPTURE_GATE_RETRIGGER_EN and a retrigger at edge s (inside GATE):
//     data for j=5..s and s+5..s+12, busy 0..s+16, filt_rst s+15,s+16,
//     done s+17.
// -----------------------------------------------------------------------------
module tb_adc_capture_gate;

   localparam int DW = 128;

   logic          aclk;
   logic          aresetn;
   logic          capture_i;
   logic [DW-1:0] adc_tdata;
   logic          adc_tvalid;
   logic          adc_tready;
   logic [DW-1:0] gate_tdata;
   logic          gate_tvalid;
   logic          gate_tready;
   logic          filt_rst_o;
   logic          busy_o;
   logic          done_o;

   int n_total;
   int n_pass;
   int edge_n;

   adc_capture_gate #(
      .DWIDTH     (DW),
      .GATE_DELAY (4),
      .GATE_LEN   (8),
      .POST_DELAY (3),
      .RESET_LEN  (2)
   ) dut (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .capture_i   (capture_i),
      .adc_tdata   (adc_tdata),
      .adc_tvalid  (adc_tvalid),
      .adc_tready  (adc_tready),
      .gate_tdata  (gate_tdata),
      .gate_tvalid (gate_tvalid),
      .gate_tready (gate_tready),
      .filt_rst_o  (filt_rst_o),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   // ---------------- clock ----------------
   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: sim time expired before summary");
      $fatal(1, "timeout");
   end

   // ---------------- helpers ----------------
   function automatic logic [DW-1:0] mk(input int n);
      logic [15:0] v;
      v = 16'(n);
      return {8{v}};
   endfunction

   task automatic chk(input string tag, input int j, input logic [DW-1:0] obs,
                      input logic [DW-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s j=%0d: got %0h expected %0h", tag, j, obs, exp);
   endtask

   // One clock edge, then settle; adc_tdata is labelled with the number of the
   // edge that will sample it.
   task automatic tick();
      @(posedge aclk);
      #1;
      edge_n++;
      adc_tdata  = mk(edge_n + 1);
      adc_tvalid = 1'($urandom_range(0, 1));
   endtask

   task automatic chk_idle(input string tag, input int j);
      chk({tag, "_tdata"}, j, gate_tdata, '0);
      chk({tag, "_busy"},  j, DW'(busy_o), '0);
      chk({tag, "_rst"},   j, DW'(filt_rst_o), '0);
      chk({tag, "_done"},  j, DW'(done_o), '0);
   endtask

   // Capture edge at j=0, capture_i held for hold_len edges, optional extra
   // pulse at edge p2 (p2<0: none); observe n_cyc cycles.
   task automatic run_seq(input string tag, input int hold_len, input int p2,
                          input int n_cyc);
      int n0;
      int s;
      bit retrig;
      logic [DW-1:0] e_d;
      bit e_busy;
      bit e_rst;
      bit e_done;
      retrig = 1'b0;
`ifdef ADC_CAPTURE_GATE_RETRIGGER_EN
      retrig = (p2 >= 0);
`endif
      s = retrig ? p2 : 0;
      capture_i = 1'b1;
      tick();
      n0 = edge_n;
      for (int j = 0; j < n_cyc; j++) begin
         if (j > 0) tick();
         capture_i = ((j + 1) < hold_len) || ((j + 1) == p2);
         if (!retrig) begin
            e_d    = (j >= 5 && j <= 12) ? mk(n0 + j) : '0;
            e_busy = (j <= 16);
            e_rst  = (j == 15) || (j == 16);
            e_done = (j == 17);
         end else begin
            e_d    = ((j >= 5 && j <= s) || (j >= s + 5 && j <= s + 12)) ? mk(n0 + j) : '0;
            e_busy = (j <= s + 16);
            e_rst  = (j == s + 15) || (j == s + 16);
            e_done = (j == s + 17);
         end
         chk({tag, "_tdata"},  j, gate_tdata, e_d);
         chk({tag, "_busy"},   j, DW'(busy_o), DW'(e_busy));
         chk({tag, "_rst"},    j, DW'(filt_rst_o), DW'(e_rst));
         chk({tag, "_done"},   j, DW'(done_o), DW'(e_done));
         chk({tag, "_tvalid"}, j, DW'(gate_tvalid), DW'(1));
         chk({tag, "_tready"}, j, DW'(adc_tready), DW'(1));
      end
      capture_i = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      n_total     = 0;
      n_pass      = 0;
      edge_n      = 0;
      aresetn     = 1'b0;
      capture_i   = 1'b0;
      gate_tready = 1'b1;
      adc_tvalid  = 1'b0;
      adc_tdata   = mk(1);

      // Reset values while held in reset.
      tick();
      tick();
      chk_idle("rst", 0);
      chk("rst_tvalid", 0, DW'(gate_tvalid), '0);
      chk("rst_tready", 0, DW'(adc_tready), DW'(1));
      #2 aresetn = 1'b1;
      tick();
      chk("rel_tvalid", 0, DW'(gate_tvalid), DW'(1));
      chk_idle("rel", 0);
      tick();

      // 1: single capture pulse.
      run_seq("s1", 1, -1, 22);
      for (int j = 0; j < 3; j++) begin tick(); chk_idle("s1_gap", j); end

      // 2: capture held for 40 cycles, no retrigger after done.
      run_seq("s2", 40, -1, 46);
      for (int j = 0; j < 3; j++) begin tick(); chk_idle("s2_gap", j); end

      // 3/4: second pulse in GATE (ignored, or restarts with the macro).
      run_seq("s34", 1, 7, 30);
      for (int j = 0; j < 3; j++) begin tick(); chk_idle("s34_gap", j); end

      // 5: asynchronous reset mid-GATE.
      capture_i = 1'b1;
      tick();
      capture_i = 1'b0;
      begin
         int n0;
         n0 = edge_n;
         repeat (7) tick();
         chk("s5_pre_tdata", 7, gate_tdata, mk(n0 + 7));
         chk("s5_pre_busy",  7, DW'(busy_o), DW'(1));
      end
      #2 aresetn = 1'b0;
      #1;
      chk_idle("s5_async", 0);
      chk("s5_async_tvalid", 0, DW'(gate_tvalid), '0);
      for (int j = 0; j < 3; j++) begin tick(); chk_idle("s5_inrst", j); end
      #3 aresetn = 1'b1;
      tick();
      chk_idle("s5_rel", 0);
      chk("s5_rel_tvalid", 0, DW'(gate_tvalid), DW'(1));
      tick();
      run_seq("s5_after", 1, -1, 20);
      for (int j = 0; j < 2; j++) begin tick(); chk_idle("s5_gap", j); end

      // 6: downstream never ready; output must be unaffected.
      gate_tready = 1'b0;
      run_seq("s6", 1, -1, 22);
      for (int j = 0; j < 3; j++) begin tick(); chk_idle("s6_gap", j); end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
